midi_parser: RTL and testbench

- Sits between the 31250-baud UART receiver and the GBMidi voice controller.
- Consumes the raw MIDI byte stream and handles running status, SysEx, system common and real-time bytes.
- Emits one decoded channel-voice event per complete message over a valid/ready handshake.
- Gives the voice logic clean note/CC/bend events instead of bytes, plus a real-time strobe for future clock sync.

---
 rtl/midi_pkg.sv | 41 ++++
 rtl/midi_parser.sv | 164 ++++++++++++++++
 tb/tb_midi_parser.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/midi_pkg.sv
// Shared types and byte constants for the MIDI byte-stream parser.
package midi_pkg;

    typedef enum logic [2:0] {
        NOTE_OFF   = 3'd0,
        NOTE_ON    = 3'd1,
        POLY_AT    = 3'd2,
        CC         = 3'd3,
        PROGRAM    = 3'd4,
        CHAN_AT    = 3'd5,
        PITCH_BEND = 3'd6
    } evt_type_e;

    // Upper nibble of channel-voice status bytes.
    localparam logic [3:0] STAT_NOTE_OFF   = 4'h8;
    localparam logic [3:0] STAT_NOTE_ON    = 4'h9;
    localparam logic [3:0] STAT_POLY_AT    = 4'hA;
    localparam logic [3:0] STAT_CC         = 4'hB;
    localparam logic [3:0] STAT_PROGRAM    = 4'hC;
    localparam logic [3:0] STAT_CHAN_AT    = 4'hD;
    localparam logic [3:0] STAT_PITCH_BEND = 4'hE;
    localparam logic [3:0] STAT_SYSTEM     = 4'hF;

    localparam logic [7:0] SYS_SYSEX     = 8'hF0;
    localparam logic [7:0] SYS_MTC_QF    = 8'hF1;
    localparam logic [7:0] SYS_SONG_POS  = 8'hF2;
    localparam logic [7:0] SYS_SONG_SEL  = 8'hF3;
    localparam logic [7:0] SYS_EOX       = 8'hF7;
    localparam logic [7:0] SYS_RT_CLOCK  = 8'hF8;
    localparam logic [7:0] SYS_RT_UNDEF1 = 8'hF9;
    localparam logic [7:0] SYS_RT_UNDEF2 = 8'hFD;

    typedef enum logic [2:0] {
        P_IDLE    = 3'd0,
        P_WAIT_D1 = 3'd1,
        P_WAIT_D2 = 3'd2,
        P_SYSEX   = 3'd3,
        P_SKIP    = 3'd4
    } parser_state_e;

endpackage

// File: rtl/midi_parser.sv
// MIDI byte-stream parser: running status, SysEx, system common and
// real-time handling, emitting one channel-voice event per message.
module midi_parser
    import midi_pkg::*;
#(
    parameter bit         OMNI    = 1'b1,
    parameter logic [3:0] CHANNEL = 4'd0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [2:0] evt_type,
    output logic [3:0] evt_ch,
    output logic [6:0] evt_d1,
    output logic [6:0] evt_d2,
    output logic       rt_strobe,
    output logic [2:0] rt_code,
    output logic [7:0] err_cnt,
    output logic [2:0] dbg_state
);

    // Handshakes: a byte transfers on a cycle where byte_valid && byte_ready;
    // an event transfers where evt_valid && evt_ready. byte_ready is the
    // registered inverse of evt_valid, so input stalls while an event waits.

    parser_state_e state;
    logic [7:0]    run_status;
    logic [6:0]    d1_q;
    logic [1:0]    skip_cnt;
    logic          msg_open;   // status seen, no message completed since

    logic          accept, is_status, is_rt, rt_pulse, is_chan;
    logic          one_byte, truncated, ch_match;
    logic          complete, err_inc;
    logic [6:0]    cmp_d1, cmp_d2;
    evt_type_e     cmp_type;

    assign accept    = byte_valid && byte_ready;
    assign is_status = byte_data[7];
    assign is_rt     = byte_data >= SYS_RT_CLOCK;
    assign rt_pulse  = is_rt && byte_data != SYS_RT_UNDEF1 && byte_data != SYS_RT_UNDEF2;
    assign is_chan   = is_status && byte_data[7:4] != STAT_SYSTEM;
    assign one_byte  = run_status[7:4] == STAT_PROGRAM || run_status[7:4] == STAT_CHAN_AT;
    assign truncated = state == P_WAIT_D2 || (state == P_WAIT_D1 && msg_open);
    assign ch_match  = OMNI || run_status[3:0] == CHANNEL;
    assign dbg_state = state;

    always_comb begin
        complete = 1'b0;
        err_inc  = 1'b0;
        cmp_d1   = d1_q;
        cmp_d2   = 7'd0;
        if (accept && !is_status) begin
            case (state)
                P_IDLE:    err_inc = 1'b1;
                P_WAIT_D1: begin
                    if (one_byte) begin
                        complete = 1'b1;
                        cmp_d1   = byte_data[6:0];
                    end
                end
                P_WAIT_D2: begin
                    complete = 1'b1;
                    cmp_d2   = byte_data[6:0];
                end
                default: ;
            endcase
        end
        if (accept && is_chan && truncated)
            err_inc = 1'b1;
        // Status nibbles 8..E map onto event types 0..6 through their low bits.
        cmp_type = evt_type_e'(run_status[6:4]);
        if (run_status[7:4] == STAT_NOTE_ON && cmp_d2 == 7'd0)
            cmp_type = NOTE_OFF;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= P_IDLE;
            run_status <= 8'd0;
            d1_q       <= 7'd0;
            skip_cnt   <= 2'd0;
            msg_open   <= 1'b0;
            byte_ready <= 1'b1;
            evt_valid  <= 1'b0;
            evt_type   <= 3'd0;
            evt_ch     <= 4'd0;
            evt_d1     <= 7'd0;
            evt_d2     <= 7'd0;
            rt_strobe  <= 1'b0;
            rt_code    <= 3'd0;
            err_cnt    <= 8'd0;
        end else begin
            rt_strobe <= accept && rt_pulse;
            if (accept && rt_pulse)
                rt_code <= byte_data[2:0];
            if (err_inc && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
            if (evt_valid && evt_ready) begin
                evt_valid  <= 1'b0;
                byte_ready <= 1'b1;
            end
            // Real-time bytes leave every piece of parse state alone.
            if (accept && !is_rt) begin
                if (is_status) begin
                    skip_cnt <= 2'd0;
                    msg_open <= 1'b0;
                    if (is_chan) begin
                        run_status <= byte_data;
                        msg_open   <= 1'b1;
                        state      <= P_WAIT_D1;
                    end else begin
                        run_status <= 8'd0;
                        case (byte_data)
                            SYS_SYSEX:    state <= P_SYSEX;
                            SYS_MTC_QF,
                            SYS_SONG_SEL: begin
                                state    <= P_SKIP;
                                skip_cnt <= 2'd1;
                            end
                            SYS_SONG_POS: begin
                                state    <= P_SKIP;
                                skip_cnt <= 2'd2;
                            end
                            default:      state <= P_IDLE;
                        endcase
                    end
                end else begin
                    case (state)
                        P_WAIT_D1: begin
                            if (!one_byte) begin
                                d1_q  <= byte_data[6:0];
                                state <= P_WAIT_D2;
                            end
                        end
                        P_WAIT_D2: state <= P_WAIT_D1;
                        P_SKIP: begin
                            skip_cnt <= skip_cnt - 2'd1;
                            if (skip_cnt == 2'd1)
                                state <= P_IDLE;
                        end
                        default: ;
                    endcase
                end
            end
            if (complete) begin
                msg_open <= 1'b0;
                if (ch_match) begin
                    evt_valid  <= 1'b1;
                    byte_ready <= 1'b0;
                    evt_type   <= cmp_type;
                    evt_ch     <= run_status[3:0];
                    evt_d1     <= cmp_d1;
                    evt_d2     <= cmp_d2;
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_parser.sv
// Directed and randomized bench for midi_parser against a message-level reference model.
module tb_midi_parser;
    import midi_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic [7:0] byte_data  [3];
    logic       byte_valid [3];
    logic       byte_ready [3];
    logic       evt_valid  [3];
    logic       evt_ready  [3];
    logic [2:0] evt_type   [3];
    logic [3:0] evt_ch     [3];
    logic [6:0] evt_d1     [3];
    logic [6:0] evt_d2     [3];
    logic       rt_strobe  [3];
    logic [2:0] rt_code    [3];
    logic [7:0] err_cnt    [3];
    logic [2:0] dbg_state  [3];

    midi_parser #(.OMNI(1'b1), .CHANNEL(4'd0)) dut_omni (
        .clk(clk), .reset_n(reset_n), .byte_data(byte_data[0]), .byte_valid(byte_valid[0]),
        .byte_ready(byte_ready[0]), .evt_valid(evt_valid[0]), .evt_ready(evt_ready[0]),
        .evt_type(evt_type[0]), .evt_ch(evt_ch[0]), .evt_d1(evt_d1[0]), .evt_d2(evt_d2[0]),
        .rt_strobe(rt_strobe[0]), .rt_code(rt_code[0]), .err_cnt(err_cnt[0]), .dbg_state(dbg_state[0]));

    midi_parser #(.OMNI(1'b0), .CHANNEL(4'd5)) dut_ch5 (
        .clk(clk), .reset_n(reset_n), .byte_data(byte_data[1]), .byte_valid(byte_valid[1]),
        .byte_ready(byte_ready[1]), .evt_valid(evt_valid[1]), .evt_ready(evt_ready[1]),
        .evt_type(evt_type[1]), .evt_ch(evt_ch[1]), .evt_d1(evt_d1[1]), .evt_d2(evt_d2[1]),
        .rt_strobe(rt_strobe[1]), .rt_code(rt_code[1]), .err_cnt(err_cnt[1]), .dbg_state(dbg_state[1]));

    midi_parser #(.OMNI(1'b0), .CHANNEL(4'd3)) dut_ch3 (
        .clk(clk), .reset_n(reset_n), .byte_data(byte_data[2]), .byte_valid(byte_valid[2]),
        .byte_ready(byte_ready[2]), .evt_valid(evt_valid[2]), .evt_ready(evt_ready[2]),
        .evt_type(evt_type[2]), .evt_ch(evt_ch[2]), .evt_d1(evt_d1[2]), .evt_d2(evt_d2[2]),
        .rt_strobe(rt_strobe[2]), .rt_code(rt_code[2]), .err_cnt(err_cnt[2]), .dbg_state(dbg_state[2]));

    int checks = 0;
    int errors = 0;

    // Reference model: message-level view of the byte stream.
    logic [7:0]  m_running;
    logic [7:0]  m_part[$];
    bit          m_open, m_sysex, m_omni;
    int          m_skip, m_err;
    logic [3:0]  m_chan;
    logic [20:0] exp_q[$];
    bit          exp_rt;
    logic [2:0]  exp_rt_code;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [20:0] fields(input int k);
        return {evt_type[k], evt_ch[k], evt_d1[k], evt_d2[k]};
    endfunction

    task automatic model_reset(input bit omni, input logic [3:0] chan);
        m_running = 8'h00;
        m_part.delete();
        m_open = 0; m_sysex = 0; m_skip = 0; m_err = 0;
        m_omni = omni; m_chan = chan;
        exp_q.delete();
        exp_rt = 0; exp_rt_code = 3'd0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int need;
        logic [2:0] t;
        logic [6:0] d2;
        exp_rt = 0;
        if (b >= 8'hF8) begin
            if (b != 8'hF9 && b != 8'hFD) begin
                exp_rt = 1;
                exp_rt_code = b[2:0];
            end
        end else if (b[7]) begin
            if (b < 8'hF0) begin
                if (m_part.size() > 0 || m_open) m_err = (m_err < 255) ? m_err + 1 : 255;
                m_running = b;
                m_open = 1;
            end else begin
                m_running = 8'h00;
                m_open = 0;
            end
            m_part.delete();
            m_sysex = (b == 8'hF0);
            m_skip  = (b == 8'hF1 || b == 8'hF3) ? 1 : (b == 8'hF2) ? 2 : 0;
        end else if (m_sysex) begin
        end else if (m_skip > 0) begin
            m_skip--;
        end else if (m_running == 8'h00) begin
            m_err = (m_err < 255) ? m_err + 1 : 255;
        end else begin
            m_part.push_back(b);
            need = (m_running[7:4] == 4'hC || m_running[7:4] == 4'hD) ? 1 : 2;
            if (m_part.size() == need) begin
                d2 = (need == 2) ? m_part[1][6:0] : 7'd0;
                t  = 3'(m_running[7:4] - 4'h8);
                if (m_running[7:4] == 4'h9 && d2 == 7'd0) t = 3'd0;
                if (m_omni || m_running[3:0] == m_chan)
                    exp_q.push_back({t, m_running[3:0], m_part[0][6:0], d2});
                m_part.delete();
                m_open = 0;
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            byte_data[k] = 8'h00; byte_valid[k] = 1'b0; evt_ready[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_byte_ready", byte_ready[k], 1);
            chk("rst_evt_valid", evt_valid[k], 0);
            chk("rst_fields", fields(k), 0);
            chk("rst_rt", {rt_strobe[k], rt_code[k]}, 0);
            chk("rst_err_cnt", err_cnt[k], 0);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send(input int k, input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        byte_data[k] = b;
        byte_valid[k] = 1'b1;
        while (!byte_ready[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready[k]) begin
            chk("byte_ready_timeout", 0, 1);
            byte_valid[k] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        byte_valid[k] = 1'b0;
        model_byte(b);
        chk("rt_strobe", rt_strobe[k], exp_rt);
        if (exp_rt) chk("rt_code", rt_code[k], exp_rt_code);
        chk("err_cnt", err_cnt[k], m_err);
        if (exp_q.size() > 0) begin
            chk("evt_valid_set", evt_valid[k], 1);
            chk("byte_ready_low", byte_ready[k], 0);
            chk("evt_fields", fields(k), exp_q[0]);
        end else begin
            chk("evt_valid_idle", evt_valid[k], 0);
        end
    endtask

    task automatic consume(input int k, input int delay);
        repeat (delay) begin
            @(negedge clk);
            chk("evt_hold", fields(k), exp_q[0]);
            chk("evt_hold_ready", byte_ready[k], 0);
        end
        @(negedge clk);
        evt_ready[k] = 1'b1;
        @(posedge clk);
        #1;
        evt_ready[k] = 1'b0;
        chk("evt_drop", evt_valid[k], 0);
        chk("byte_ready_back", byte_ready[k], 1);
        void'(exp_q.pop_front());
    endtask

    task automatic send_list(input int k, input logic [7:0] bytes[$]);
        foreach (bytes[i]) begin
            send(k, bytes[i]);
            if (exp_q.size() > 0) consume(k, 0);
        end
    endtask

    function automatic logic [7:0] rand_byte(input bit favour_ch5);
        int r;
        logic [7:0] b;
        r = $urandom_range(0, 99);
        if (r < 50)
            b = 8'($urandom_range(0, 127));
        else if (r < 72) begin
            b[7:4] = 4'($urandom_range(8, 14));
            b[3:0] = (favour_ch5 && $urandom_range(0, 1) == 1) ? 4'd5 : 4'($urandom_range(0, 15));
        end else if (r < 86)
            b = 8'($urandom_range(8'hF8, 8'hFF));
        else
            b = 8'($urandom_range(8'hF0, 8'hF7));
        return b;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        model_reset(1'b1, 4'd0);

        // Single note-on, held while the consumer stalls.
        send(0, 8'h90); send(0, 8'h3C); send(0, 8'h64);
        chk("note_on_literal", fields(0), {3'd1, 4'd0, 7'h3C, 7'h64});
        @(negedge clk);
        byte_data[0] = 8'hF8; byte_valid[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_ready", byte_ready[0], 0);
            chk("stall_strobe", rt_strobe[0], 0);
            chk("stall_fields", fields(0), exp_q[0]);
        end
        evt_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        evt_ready[0] = 1'b0; byte_valid[0] = 1'b0;
        chk("simul_evt_drop", evt_valid[0], 0);
        chk("simul_no_take", rt_strobe[0], 0);
        void'(exp_q.pop_front());

        // Running status with a velocity-zero note-on.
        send_list(0, '{8'h92, 8'h40, 8'h50, 8'h41, 8'h00});

        // Controller split by a timing clock.
        send_list(0, '{8'hB0, 8'h01});
        send(0, 8'hF8);
        @(posedge clk);
        #1;
        chk("rt_one_cycle", rt_strobe[0], 0);
        send(0, 8'h7F);
        chk("cc_literal", fields(0), {3'd3, 4'd0, 7'h01, 7'h7F});
        consume(0, 2);

        // SysEx is swallowed; the trailing byte is stray.
        do_reset();
        model_reset(1'b1, 4'd0);
        send_list(0, '{8'hF0, 8'h7E, 8'h11, 8'h22, 8'hF7, 8'h45});
        chk("sysex_err", err_cnt[0], 1);

        // Channel filtering.
        do_reset();
        model_reset(1'b0, 4'd5);
        send_list(1, '{8'hE5, 8'h00, 8'h40});
        model_reset(1'b0, 4'd3);
        send_list(2, '{8'hE5, 8'h00, 8'h40});
        chk("filtered_err", err_cnt[2], 0);

        // Truncation followed by program change, then error saturation.
        do_reset();
        model_reset(1'b1, 4'd0);
        send_list(0, '{8'h90, 8'h3C});
        send(0, 8'hC1); send(0, 8'h07);
        chk("prog_literal", fields(0), {3'd4, 4'd1, 7'h07, 7'h00});
        chk("trunc_err", err_cnt[0], 1);
        consume(0, 0);
        send(0, 8'hF7);
        for (int i = 0; i < 300; i++) send(0, 8'($urandom_range(0, 127)));
        chk("err_saturated", err_cnt[0], 255);

        // Reset while an event is waiting.
        send_list(0, '{8'h90, 8'h3C});
        send(0, 8'h64);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_valid", evt_valid[0], 0);
        chk("async_rst_ready", byte_ready[0], 1);
        chk("async_rst_err", err_cnt[0], 0);
        #1 reset_n = 1'b1;
        model_reset(1'b1, 4'd0);

        // Randomized streams against the model.
        for (int i = 0; i < 250; i++) begin
            send(0, rand_byte(1'b0));
            if (exp_q.size() > 0) consume(0, $urandom_range(0, 3));
        end
        do_reset();
        model_reset(1'b0, 4'd5);
        for (int i = 0; i < 250; i++) begin
            send(1, rand_byte(1'b1));
            if (exp_q.size() > 0) consume(1, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
